// File: rtl/prog_sequencer.sv
// Purpose: launches up to three fixed-address programs in turn, counting RUN cycles and forcing a stop at MAX_CYCLES.
// Latency: all outputs are Moore outputs from registered state; an input change shows on outputs one edge later.
// Backpressure: none; Start is a level request (launch on release), Halt is an end-of-program strobe honoured only in RUN.
module prog_sequencer #(
  parameter logic [9:0] BASE0      = 10'h000,
  parameter logic [9:0] BASE1      = 10'h100,
  parameter logic [9:0] BASE2      = 10'h200,
  parameter int         MAX_CYCLES = 1000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Halt,
  output logic        FetchHold,
  output logic        PcLoad,
  output logic [9:0]  PcLoadVal,
  output logic [1:0]  ProgIdx,
  output logic        Done,
  output logic        Timeout,
  output logic [15:0] CycleCnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Pre-increment count at which the forced stop fires, leaving CycleCnt at MAX_CYCLES.
  localparam logic [15:0] LAST_CNT = 16'(MAX_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  prog_idx_q, prog_idx_d;
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic        timeout_q, timeout_d;

  // State and datapath registers; reset beats every other input on the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      prog_idx_q  <= 2'd0;
      cycle_cnt_q <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prog_idx_q  <= prog_idx_d;
      cycle_cnt_q <= cycle_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state logic; in RUN an abort (Start) outranks Halt, which outranks the cycle limit.
  always_comb begin
    state_d     = state_q;
    prog_idx_d  = prog_idx_q;
    cycle_cnt_d = cycle_cnt_q;
    timeout_d   = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!Start) state_d = S_LOAD;
      end
      S_LOAD: begin
        cycle_cnt_d = 16'd0;
        timeout_d   = 1'b0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        cycle_cnt_d = cycle_cnt_q + 16'd1;
        if (Start) begin
          state_d = S_ARMED;
        end else if (Halt) begin
          state_d   = S_DONE;
          timeout_d = 1'b0;
        end else if (cycle_cnt_q == LAST_CNT) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_DONE: begin
        if (Start) begin
          state_d    = S_ARMED;
          prog_idx_d = (prog_idx_q == 2'd2) ? 2'd0 : prog_idx_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Start address follows the registered program index; index 3 is unreachable.
  always_comb begin
    PcLoadVal = BASE0;
    case (prog_idx_q)
      2'd1:    PcLoadVal = BASE1;
      2'd2:    PcLoadVal = BASE2;
      default: PcLoadVal = BASE0;
    endcase
  end

  assign FetchHold = (state_q != S_RUN);
  assign PcLoad    = (state_q == S_LOAD);
  assign Done      = (state_q == S_DONE);
  assign ProgIdx   = prog_idx_q;
  assign Timeout   = timeout_q;
  assign CycleCnt  = cycle_cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Purpose: directed self-checking bench for prog_sequencer with default parameters.
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: not applicable.
module tb_prog_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Halt = 1'b0;
  logic        FetchHold;
  logic        PcLoad;
  logic [9:0]  PcLoadVal;
  logic [1:0]  ProgIdx;
  logic        Done;
  logic        Timeout;
  logic [15:0] CycleCnt;

  int checks = 0;
  int failures = 0;

  prog_sequencer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Halt      (Halt),
    .FetchHold (FetchHold),
    .PcLoad    (PcLoad),
    .PcLoadVal (PcLoadVal),
    .ProgIdx   (ProgIdx),
    .Done      (Done),
    .Timeout   (Timeout),
    .CycleCnt  (CycleCnt)
  );

  always #5 Clk = ~Clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // From DONE (or IDLE): Start pulse, release, check LOAD, land on RUN cycle 1.
  task automatic launch(input logic [1:0] idx, input logic [9:0] base, input string tag);
    Start = 1'b1;
    step(1);
    chk({tag, "_armed_idx"}, 32'(ProgIdx), 32'(idx));
    chk({tag, "_armed_done"}, 32'(Done), 32'd0);
    Start = 1'b0;
    step(1);
    chk({tag, "_load_pcload"}, 32'(PcLoad), 32'd1);
    chk({tag, "_load_val"}, 32'(PcLoadVal), 32'(base));
    step(1);
    chk({tag, "_run_pcload"}, 32'(PcLoad), 32'd0);
    chk({tag, "_run_hold"}, 32'(FetchHold), 32'd0);
    chk({tag, "_run_cnt"}, 32'(CycleCnt), 32'd0);
    chk({tag, "_run_to"}, 32'(Timeout), 32'd0);
  endtask

  initial begin
    // Reset state
    step(2);
    Reset = 1'b0;
    step(1);
    chk("rst_hold", 32'(FetchHold), 32'd1);
    chk("rst_pcload", 32'(PcLoad), 32'd0);
    chk("rst_val", 32'(PcLoadVal), 32'h000);
    chk("rst_idx", 32'(ProgIdx), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_to", 32'(Timeout), 32'd0);
    chk("rst_cnt", 32'(CycleCnt), 32'd0);
    // Halt ignored in IDLE
    Halt = 1'b1;
    step(2);
    Halt = 1'b0;
    chk("idle_halt_pcload", 32'(PcLoad), 32'd0);
    chk("idle_halt_hold", 32'(FetchHold), 32'd1);

    // Launch and halt: Start high 3 cycles
    Start = 1'b1;
    step(3);
    chk("arm_pcload", 32'(PcLoad), 32'd0);
    chk("arm_hold", 32'(FetchHold), 32'd1);
    Start = 1'b0;
    step(1);
    chk("l0_pcload", 32'(PcLoad), 32'd1);
    chk("l0_val", 32'(PcLoadVal), 32'h000);
    chk("l0_hold", 32'(FetchHold), 32'd1);
    step(1);
    chk("r0_pcload", 32'(PcLoad), 32'd0);
    chk("r0_hold", 32'(FetchHold), 32'd0);
    step(9);
    chk("r0_cyc10_cnt", 32'(CycleCnt), 32'd9);
    Halt = 1'b1;
    step(1);
    Halt = 1'b0;
    chk("h0_done", 32'(Done), 32'd1);
    chk("h0_cnt", 32'(CycleCnt), 32'd10);
    chk("h0_to", 32'(Timeout), 32'd0);
    chk("h0_hold", 32'(FetchHold), 32'd1);
    // DONE frozen, Halt ignored
    Halt = 1'b1;
    step(3);
    Halt = 1'b0;
    chk("h0_frozen_cnt", 32'(CycleCnt), 32'd10);
    chk("h0_frozen_done", 32'(Done), 32'd1);

    // Program series
    launch(2'd1, 10'h100, "p1");
    Halt = 1'b1;
    step(1);
    Halt = 1'b0;
    chk("p1_cnt", 32'(CycleCnt), 32'd1);
    launch(2'd2, 10'h200, "p2");
    Halt = 1'b1;
    step(1);
    Halt = 1'b0;
    chk("p2_done", 32'(Done), 32'd1);
    launch(2'd0, 10'h000, "p0");

    // Timeout on program 0
    step(999);
    chk("to_pre_cnt", 32'(CycleCnt), 32'd999);
    chk("to_pre_done", 32'(Done), 32'd0);
    chk("to_pre_hold", 32'(FetchHold), 32'd0);
    step(1);
    chk("to_done", 32'(Done), 32'd1);
    chk("to_to", 32'(Timeout), 32'd1);
    chk("to_cnt", 32'(CycleCnt), 32'd1000);
    chk("to_hold", 32'(FetchHold), 32'd1);
    step(2);
    chk("to_frozen", 32'(Timeout), 32'd1);

    // Halt vs timeout on program 1 (launch also checks Timeout cleared)
    launch(2'd1, 10'h100, "hv");
    step(999);
    Halt = 1'b1;
    step(1);
    Halt = 1'b0;
    chk("hv_done", 32'(Done), 32'd1);
    chk("hv_to", 32'(Timeout), 32'd0);
    chk("hv_cnt", 32'(CycleCnt), 32'd1000);

    // Abort on RUN cycle 5 of program 2, with Halt also high
    launch(2'd2, 10'h200, "ab");
    step(4);
    chk("ab_cyc5_cnt", 32'(CycleCnt), 32'd4);
    Start = 1'b1;
    Halt = 1'b1;
    step(1);
    Halt = 1'b0;
    chk("ab_done", 32'(Done), 32'd0);
    chk("ab_idx", 32'(ProgIdx), 32'd2);
    chk("ab_hold", 32'(FetchHold), 32'd1);
    chk("ab_pcload", 32'(PcLoad), 32'd0);
    step(2);
    chk("ab_hold_idx", 32'(ProgIdx), 32'd2);
    Start = 1'b0;
    step(1);
    chk("ab_load", 32'(PcLoad), 32'd1);
    chk("ab_val", 32'(PcLoadVal), 32'h200);
    step(1);
    chk("ab_restart_cnt", 32'(CycleCnt), 32'd0);
    chk("ab_restart_hold", 32'(FetchHold), 32'd0);

    // Reset on RUN cycle 7 of program 2, with Start/Halt asserted too
    step(6);
    chk("rr_cyc7_cnt", 32'(CycleCnt), 32'd6);
    Reset = 1'b1;
    Start = 1'b1;
    Halt = 1'b1;
    step(1);
    Reset = 1'b0;
    Start = 1'b0;
    Halt = 1'b0;
    chk("rr_idx", 32'(ProgIdx), 32'd0);
    chk("rr_cnt", 32'(CycleCnt), 32'd0);
    chk("rr_hold", 32'(FetchHold), 32'd1);
    chk("rr_done", 32'(Done), 32'd0);
    chk("rr_val", 32'(PcLoadVal), 32'h000);
    chk("rr_pcload", 32'(PcLoad), 32'd0);
    step(2);
    chk("rr_idle_pcload", 32'(PcLoad), 32'd0);
    chk("rr_idle_cnt", 32'(CycleCnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
